// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP layer datapath and its sequencer.
package mlp_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FRAC_BITS  = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } layer_seq_state_t;

endpackage

// File: rtl/mac_watchdog.sv
// Cycle counter that watches a MAC in flight. clr restarts it, en counts,
// timeout flags the MAC_TIMEOUT-th counted cycle.
module mac_watchdog #(
    parameter int MAC_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CNT_W = $clog2(MAC_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(MAC_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count enabled cycles; hold at the terminal value rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != TERM_CNT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout = en && (cnt_q == TERM_CNT);

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Time-multiplexes one external sequential MAC over all neurons of a
// fully-connected layer. Optional build macro LAYER_SEQ_RELU_EN applies a
// ReLU to every stored MAC result; a timed-out neuron always stores 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for an activation vector
// S_FETCH | read strobe for weight row / bias of neuron j
// S_ISSUE | row data present; start pulse to the MAC
// S_WAIT  | waiting for MAC result, watchdog running
// S_DONE  | output vector valid, waiting for consumer
module mlp_layer_sequencer
    import mlp_pkg::*;
#(
    parameter int INPUT_WIDTH = 3,
    parameter int NUM_NEURONS = 4,
    parameter int MAC_TIMEOUT = 64,
    localparam int ADDR_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [INPUT_WIDTH*DATA_WIDTH-1:0] a_vec,
    output logic                              w_rd_en,
    output logic [ADDR_W-1:0]                 w_addr,
    input  logic [INPUT_WIDTH*DATA_WIDTH-1:0] w_row,
    input  logic [DATA_WIDTH-1:0]             b_data,
    output logic                              mac_valid_in,
    output logic [INPUT_WIDTH*DATA_WIDTH-1:0] mac_a_vec,
    output logic [INPUT_WIDTH*DATA_WIDTH-1:0] mac_w_vec,
    output logic [DATA_WIDTH-1:0]             mac_bias,
    input  logic                              mac_valid_out,
    input  logic [DATA_WIDTH-1:0]             mac_result,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_NEURONS*DATA_WIDTH-1:0] out_vec,
    output logic                              busy,
    output logic                              err
);

    layer_seq_state_t state_q, state_d;

    logic [ADDR_W-1:0]                 j_q;
    logic [INPUT_WIDTH*DATA_WIDTH-1:0] a_q;
    logic [INPUT_WIDTH*DATA_WIDTH-1:0] w_q;
    logic [DATA_WIDTH-1:0]             b_q;
    logic [NUM_NEURONS*DATA_WIDTH-1:0] out_q;
    logic                              err_q;

    logic                  timeout;
    logic                  accept;
    logic                  slot_wr;
    logic                  last_neuron;
    logic [DATA_WIDTH-1:0] result_pp;
    logic [DATA_WIDTH-1:0] slot_data;

    mac_watchdog #(
        .MAC_TIMEOUT (MAC_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_q == S_ISSUE),
        .en      (state_q == S_WAIT),
        .timeout (timeout)
    );

`ifdef LAYER_SEQ_RELU_EN
    assign result_pp = mac_result[DATA_WIDTH-1] ? '0 : mac_result;
`else
    assign result_pp = mac_result;
`endif

    assign accept      = (state_q == S_IDLE) && in_valid;
    assign slot_wr     = (state_q == S_WAIT) && (mac_valid_out || timeout);
    assign last_neuron = (j_q == ADDR_W'(NUM_NEURONS - 1));
    // A real result wins over a timeout landing in the same cycle.
    assign slot_data   = mac_valid_out ? result_pp : '0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs. During ISSUE the MAC operands come
    // straight from the memory so they are valid alongside the start pulse.
    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b0;
        w_rd_en      = 1'b0;
        mac_valid_in = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        mac_w_vec    = w_q;
        mac_bias     = b_q;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = S_FETCH;
            end
            S_FETCH: begin
                w_rd_en = 1'b1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                mac_valid_in = 1'b1;
                mac_w_vec    = w_row;
                mac_bias     = b_data;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                if (slot_wr) state_d = last_neuron ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand latches, neuron index, result slots and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            w_q   <= '0;
            b_q   <= '0;
            j_q   <= '0;
            out_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                a_q   <= a_vec;
                j_q   <= '0;
                err_q <= 1'b0;
            end
            if (state_q == S_ISSUE) begin
                w_q <= w_row;
                b_q <= b_data;
            end
            if (slot_wr) begin
                for (int k = 0; k < NUM_NEURONS; k++) begin
                    if (j_q == ADDR_W'(k)) out_q[k*DATA_WIDTH +: DATA_WIDTH] <= slot_data;
                end
                if (!last_neuron) j_q <= j_q + 1'b1;
                if (!mac_valid_out) err_q <= 1'b1;
            end
        end
    end

    assign w_addr    = j_q;
    assign mac_a_vec = a_q;
    assign out_vec   = out_q;
    assign err       = err_q;

endmodule
